m_axi_read_engine: RTL
======================

Name: m_axi_read_engine

Overview:
- AXI4-Lite master read engine for the DFX sequencer; reads DMA and ICAP status and descriptor registers on behalf of the control FSM.
- Accepts one command at a time. Two modes:
  - SEQ: reads N consecutive words, with up to MAX_OUTSTANDING ARs in flight, and streams the data out.
  - POLL: re-reads one address until a masked compare matches or an attempt limit expires.
- Reports completion with a one-cycle done pulse and a status code.

Parameters:
- GLOB_ADDR_WIDTH, 32, AXI address width.
- GLOB_DATA_WIDTH, 32, AXI data width; address stride = GLOB_DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum ARs accepted without an R beat (1..15).
- CNT_WIDTH, 8, width of the SEQ word count.
- POLL_WIDTH, 16, width of the POLL attempt limit.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_mode  in  1  0=SEQ, 1=POLL.
- cmd_addr  in  GLOB_ADDR_WIDTH  base/poll address.
- cmd_len  in  CNT_WIDTH  SEQ word count.
- cmd_mask  in  GLOB_DATA_WIDTH  POLL compare mask.
- cmd_expect  in  GLOB_DATA_WIDTH  POLL expected value.
- cmd_limit  in  POLL_WIDTH  POLL max attempts (0 treated as 1).
- rsp_valid  out  1  SEQ read word valid.
- rsp_data  out  GLOB_DATA_WIDTH  SEQ read word.
- rsp_ready  in  1  consumer accepts word.
- done  out  1  one-cycle completion pulse.
- done_status  out  2  00 OK, 01 AXI error, 10 poll timeout; held until next command.
- last_data  out  GLOB_DATA_WIDTH  last R data received; held.
- busy  out  1  state != IDLE.
- M_AXI_ARADDR  out  GLOB_ADDR_WIDTH  read address.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  GLOB_DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; all counters cleared.
  - ARVALID=0, done=0, rsp_valid=0, done_status=00, last_data=0, busy=0.
  - M_AXI_ARADDR=0.
- Reset mid-operation:
  - Same state as above on the next edge; no done pulse.
  - Any R beats still in flight are absorbed in IDLE.
- States:
  - IDLE → RUN on cmd_valid&cmd_ready. Command fields are latched; done_status and the error flag are cleared.
  - RUN → DRAIN when every AR has been issued.
  - DRAIN → IDLE on the last R handshake, with done=1 in that same edge's following cycle.
  - SEQ with cmd_len=0: IDLE→IDLE, done pulses one cycle after acceptance, status 00, no AXI traffic.
- Handshake counters:
  - issued counts AR handshakes (ARVALID&ARREADY).
  - received counts R handshakes (RVALID&RREADY).
  - outstanding = +1 per AR handshake, -1 per R handshake; unchanged when both occur in the same cycle.
- AXI AR rules:
  - ARADDR/ARVALID are registered.
  - Once ARVALID is high, ARVALID and ARADDR stay stable until ARREADY.
  - ARVALID never depends combinationally on ARREADY.
- SEQ mode:
  - ARVALID is asserted while issued<cmd_len and outstanding<MAX_OUTSTANDING. This includes the cycle after an AR handshake, so back-to-back issue reaches 1 AR/cycle.
  - ARADDR = cmd_addr + issued*(GLOB_DATA_WIDTH/8), modulo 2^GLOB_ADDR_WIDTH (wraps silently).
  - R path is combinational pass-through: rsp_valid=RVALID, rsp_data=RDATA, RREADY=rsp_ready.
  - Any RRESP != 00 on a handshake sets the sticky error flag. The read continues; done_status=01 at done.
  - Word order equals address order; AXI-Lite returns reads in order.
- POLL mode:
  - One read outstanding at a time; address is always cmd_addr.
  - RREADY=1; rsp_valid=0.
  - On each R handshake, last_data←RDATA and attempts increments.
  - Check order on each R handshake:
    1. RRESP != 00 → finish with 01.
    2. Else (RDATA & mask)==(expect & mask) → finish with 00.
    3. Else attempts==max(cmd_limit,1) → finish with 10.
    4. Else reissue AR on the next cycle.
  - Minimum re-poll period: 2 cycles between AR issues, with ARREADY and RVALID both immediate.
- last_data in SEQ mode: updated on every R handshake.
- IDLE: RREADY=1, and stray beats are discarded without any effect.
- done_status and last_data update in the same cycle as the done pulse.
- cmd_ready=0 from acceptance through the done cycle. A new command can be accepted the cycle after done.

Test Plan:
- SEQ, addr=0x1000, len=4, slave ARREADY=1, RDATA=addr, rsp_ready=1:
  - ARADDR sequence is 0x1000, 0x1004, 0x1008, 0x100C.
  - rsp_data words are 0x1000, 0x1004, 0x1008, 0x100C.
  - done once, status 00, last_data=0x100C.
- SEQ, len=10, MAX_OUTSTANDING=4, slave withholds RVALID for 20 cycles:
  - Exactly 4 ARs are issued and ARVALID then drops.
  - After release: 10 rsp words in order, done once.
- SEQ, len=3, addr=0xFFFFFFFC:
  - ARADDR sequence is 0xFFFFFFFC, 0x0, 0x4.
  - Beat 2 RRESP=10: all 3 words are delivered, done_status=01.
- POLL, mask=0x1, expect=0x1, limit=5, slave returns 0,0,1:
  - 3 ARs issued, done, status 00, last_data=1, rsp_valid never high.
- POLL, limit=3, slave always returns 0:
  - 3 ARs, done, status 10.
  - Repeat with limit=0: 1 AR, status 10.
- Mid-SEQ reset with 2 reads outstanding:
  - Next cycle ARVALID=0, busy=0, no done.
  - The 2 late R beats are accepted with RREADY=1 and produce no rsp_valid.
  - A new len=1 command then completes normally.

Source files
------------

// File: rtl/m_axi_read_engine.sv
// m_axi_read_engine
//   AXI4-Lite master read engine. It accepts one command at a time and runs it
//   in one of two modes:
//     SEQ  : reads cmd_len consecutive words starting at cmd_addr, keeping up to
//            MAX_OUTSTANDING ARs in flight, and streams the data out on rsp_*.
//     POLL : re-reads cmd_addr until (RDATA & mask) == (expect & mask), an
//            error response arrives, or max(cmd_limit,1) attempts have been made.
//   Completion is signalled by a one-cycle done pulse and a held status code.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   cmd_*               command handshake and fields (mode 0=SEQ, 1=POLL)
//   rsp_valid/data/ready SEQ read-data stream (pass-through of the R channel)
//   done, done_status   completion pulse; 00 OK, 01 AXI error, 10 poll timeout
//   last_data           last R data received while a command was active
//   busy                engine is not idle
//   M_AXI_AR*, M_AXI_R* AXI4-Lite read address / read data channels
module m_axi_read_engine #(
  parameter int unsigned GLOB_ADDR_WIDTH = 32,
  parameter int unsigned GLOB_DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 8,
  parameter int unsigned POLL_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_mode,
  input  logic [GLOB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]       cmd_len,
  input  logic [GLOB_DATA_WIDTH-1:0] cmd_mask,
  input  logic [GLOB_DATA_WIDTH-1:0] cmd_expect,
  input  logic [POLL_WIDTH-1:0]      cmd_limit,
  output logic                       rsp_valid,
  output logic [GLOB_DATA_WIDTH-1:0] rsp_data,
  input  logic                       rsp_ready,
  output logic                       done,
  output logic [1:0]                 done_status,
  output logic [GLOB_DATA_WIDTH-1:0] last_data,
  output logic                       busy,
  output logic [GLOB_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  input  logic [GLOB_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY
);

  localparam logic [GLOB_ADDR_WIDTH-1:0] STRIDE = GLOB_ADDR_WIDTH'(GLOB_DATA_WIDTH / 8);
  localparam logic [3:0]                 MAX_OS = 4'(MAX_OUTSTANDING);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_AXI_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                     state_q;
  logic                       mode_q;
  logic [GLOB_DATA_WIDTH-1:0] mask_q;
  logic [GLOB_DATA_WIDTH-1:0] expect_q;
  logic [CNT_WIDTH-1:0]       len_q;
  logic [POLL_WIDTH-1:0]      limit_q;
  logic [CNT_WIDTH-1:0]       issued_q;
  logic [CNT_WIDTH-1:0]       received_q;
  logic [3:0]                 outstanding_q;
  logic [POLL_WIDTH-1:0]      attempts_q;
  logic                       err_q;
  logic                       arvalid_q;
  logic [GLOB_ADDR_WIDTH-1:0] araddr_q;
  logic                       done_q;
  logic [1:0]                 status_q;
  logic [GLOB_DATA_WIDTH-1:0] last_data_q;

  logic                       active;
  logic                       seq_active;
  logic                       ar_hs;
  logic                       r_hs;
  logic                       r_err;
  logic                       poll_match;
  logic [CNT_WIDTH-1:0]       issued_d;
  logic [CNT_WIDTH-1:0]       received_d;
  logic [3:0]                 outstanding_d;
  logic [POLL_WIDTH-1:0]      attempts_d;
  logic                       err_d;

  // R channel: SEQ streams straight through to the consumer; otherwise
  // (POLL, IDLE) beats are always accepted and never presented on rsp_*.
  assign active       = (state_q != S_IDLE);
  assign seq_active   = active && !mode_q;
  assign M_AXI_RREADY = seq_active ? rsp_ready : 1'b1;
  assign rsp_valid    = seq_active && M_AXI_RVALID;
  assign rsp_data     = M_AXI_RDATA;

  // Ready is withheld during the done cycle so the pulse and the next
  // acceptance never overlap, even for a zero-length SEQ that stays in IDLE.
  assign cmd_ready     = (state_q == S_IDLE) && !done_q;
  assign busy          = active;
  assign done          = done_q;
  assign done_status   = status_q;
  assign last_data     = last_data_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = araddr_q;

  always_comb begin
    ar_hs         = arvalid_q && M_AXI_ARREADY;
    r_hs          = active && M_AXI_RVALID && M_AXI_RREADY;
    r_err         = (M_AXI_RRESP != 2'b00);
    poll_match    = ((M_AXI_RDATA ^ expect_q) & mask_q) == '0;
    issued_d      = issued_q + CNT_WIDTH'(ar_hs);
    received_d    = received_q + CNT_WIDTH'(r_hs);
    outstanding_d = outstanding_q + 4'(ar_hs) - 4'(r_hs);
    attempts_d    = attempts_q + POLL_WIDTH'(r_hs);
    err_d         = err_q || (r_hs && r_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      mask_q        <= '0;
      expect_q      <= '0;
      len_q         <= '0;
      limit_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      attempts_q    <= '0;
      err_q         <= 1'b0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      done_q        <= 1'b0;
      status_q      <= ST_OK;
      last_data_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            mode_q        <= cmd_mode;
            mask_q        <= cmd_mask;
            expect_q      <= cmd_expect;
            len_q         <= cmd_len;
            limit_q       <= (cmd_limit == '0) ? POLL_WIDTH'(1) : cmd_limit;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
            attempts_q    <= '0;
            err_q         <= 1'b0;
            status_q      <= ST_OK;
            araddr_q      <= cmd_addr;
            if (!cmd_mode && (cmd_len == '0)) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              arvalid_q <= 1'b1;
            end
          end
        end

        S_RUN, S_DRAIN: begin
          issued_q      <= issued_d;
          received_q    <= received_d;
          outstanding_q <= outstanding_d;
          attempts_q    <= attempts_d;
          err_q         <= err_d;
          if (r_hs) last_data_q <= M_AXI_RDATA;

          if (!mode_q) begin
            // Next-cycle ARVALID from next-cycle counters: a pending AR can only
            // see outstanding shrink, so it stays stable until accepted, and a
            // handshake can be followed immediately by the next AR.
            if (ar_hs) araddr_q <= araddr_q + STRIDE;
            arvalid_q <= (issued_d < len_q) && (outstanding_d < MAX_OS);
            if (r_hs && (received_d == len_q)) begin
              state_q   <= S_IDLE;
              arvalid_q <= 1'b0;
              done_q    <= 1'b1;
              status_q  <= err_d ? ST_AXI_ERR : ST_OK;
            end else if (issued_d == len_q) begin
              state_q <= S_DRAIN;
            end
          end else begin
            if (ar_hs) begin
              arvalid_q <= 1'b0;
              state_q   <= S_DRAIN;
            end
            if (r_hs) begin
              if (r_err) begin
                state_q  <= S_IDLE;
                done_q   <= 1'b1;
                status_q <= ST_AXI_ERR;
              end else if (poll_match) begin
                state_q  <= S_IDLE;
                done_q   <= 1'b1;
                status_q <= ST_OK;
              end else if (attempts_d == limit_q) begin
                state_q  <= S_IDLE;
                done_q   <= 1'b1;
                status_q <= ST_TIMEOUT;
              end else begin
                state_q   <= S_RUN;
                arvalid_q <= 1'b1;
              end
            end
          end
        end

        default: begin
          state_q   <= S_IDLE;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
